// File: rtl/gate_seq_pkg.sv
// Shared state encoding and default widths for the gate delay sequencer.
package gate_seq_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 200;
  localparam int SETTLE_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_delay_sequencer.sv
// Applies one vector to a 2-input gate under test, counts clocks until its synced
// output matches the expected value, then watches that output for glitches.
module gate_delay_sequencer
  import gate_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SETTLE  = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             expect_y,
  input  logic             gut_y,
  output logic             drive_a,
  output logic             drive_b,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             glitch,
  output logic [CNT_W-1:0] delay_cnt
);

  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             lat_a;
  logic             lat_b;
  logic             lat_exp;
  logic             y_s;

  // The idle NAND output is 1, so the synchronizer resets to 1 to avoid a false edge.
  sync_2ff #(.RST_VAL(1'b1)) u_sync_y (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gut_y),
    .q     (y_s)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_a     <= 1'b0;
      lat_b     <= 1'b0;
      lat_exp   <= 1'b0;
      drive_a   <= 1'b0;
      drive_b   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      glitch    <= 1'b0;
      delay_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            lat_a     <= vec_a;
            lat_b     <= vec_b;
            lat_exp   <= expect_y;
            timeout   <= 1'b0;
            glitch    <= 1'b0;
            delay_cnt <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          drive_a <= lat_a;
          drive_b <= lat_b;
          cnt     <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (y_s == lat_exp) begin
            delay_cnt <= cnt;
            cnt       <= '0;
            state     <= ST_SETTLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              timeout   <= 1'b1;
              delay_cnt <= TIMEOUT_C;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        // The full settle window always runs so every measurement takes a fixed tail.
        ST_SETTLE: begin
          if (y_s != lat_exp) begin
            glitch <= 1'b1;
          end
          if (cnt == SETTLE_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
